// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

  // Default operand widths: an 8-bit product divided by a 4-bit multiplier operand.
  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Iteration counter width for the default dividend width.
  localparam int CNT_W_DEF = $clog2(DIVIDEND_W_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  // Counter width for an arbitrary dividend width; never narrower than one bit.
  function automatic int cnt_width(input int iterations);
    return (iterations > 1) ? $clog2(iterations) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] r_i,      // partial remainder, already truncated to DIVISOR_W bits
  input  logic                 n_bit_i,  // next dividend bit (MSB first)
  input  logic [DIVISOR_W-1:0] d_i,      // divisor
  output logic [DIVISOR_W:0]   r_o,      // new partial remainder
  output logic                 q_bit_o   // quotient bit produced by this iteration
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] d_ext;

  // Shift the dividend bit into the remainder, subtract the divisor when it fits.
  always_comb begin
    trial = {r_i, n_bit_i};
    d_ext = {1'b0, d_i};
    if (trial >= d_ext) begin
      r_o     = trial - d_ext;
      q_bit_o = 1'b1;
    end else begin
      r_o     = trial;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider with start/busy/done handshake; one quotient bit per cycle.
// Latency: done pulses DIVIDEND_W cycles after an accepted start (zero divisor with DIV_ZERO_DETECT_EN: next cycle).
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, never queued.
// Optional build macro: DIV_ZERO_DETECT_EN (zero divisor short-circuits the run and raises div_by_zero).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Dividend shift register; quotient bits enter at the LSB as dividend bits leave the MSB,
  // so after the last iteration it holds the full quotient.
  logic [DIVIDEND_W-1:0] n_q, n_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_q;
  logic                  zero_skip;
  logic                  zero_accept;
  logic                  last_iter;
  // The remainder MSB only exists to hold the trial result; it is dropped before the next shift.
  logic                  unused_r_msb;

  assign unused_r_msb = r_q[DIVISOR_W];

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_i     (r_q[DIVISOR_W-1:0]),
    .n_bit_i (n_q[DIVIDEND_W-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_q)
  );

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (divisor_i == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign zero_accept = (state_q == IDLE) && start_i && zero_skip;
  assign last_iter   = (state_q == RUN) && (cnt_q == LAST_CNT);

  // Next-state logic: accept in IDLE, one restoring step per cycle in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (zero_accept) begin
          // Zero divisor short-circuit: same result a full run would give, delivered immediately.
          quot_d = '1;
          rem_d  = dividend_i[DIVISOR_W-1:0];
          done_d = 1'b1;
        end else if (start_i) begin
          n_d     = dividend_i;
          d_d     = divisor_i;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        n_d   = {n_q[DIVIDEND_W-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          quot_d  = {n_q[DIVIDEND_W-2:0], step_q};
          rem_d   = step_r[DIVISOR_W-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run and clears the results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;

  // Zero-divisor flag: set by a short-circuited start, cleared by the next normal completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbz_q <= 1'b0;
    end else if (zero_accept) begin
      dbz_q <= 1'b1;
    end else if (last_iter) begin
      dbz_q <= 1'b0;
    end
  end

  assign div_by_zero_o = dbz_q;
`else
  assign div_by_zero_o = 1'b0;
`endif

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, corner sequences, random and sweep.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_restoring_divider dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (div_by_zero)
  );

`ifdef DIV_ZERO_DETECT_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 0;
  localparam int ZFLAG = 1;
`else
  localparam int ZLAT  = 8;
  localparam int ZBUSY = 8;
  localparam int ZFLAG = 0;
`endif

  localparam int WAIT_LIMIT = 40;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int z;
    int lat;
    int bcnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones and the low dividend bits.
  function automatic void ref_div(input int n, input int d, output int q, output int r);
    if (d == 0) begin
      q = 255;
      r = n % 16;
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  // lat counts posedges after the accept edge; bcnt counts sampled cycles with busy high.
  task automatic do_div(input int n, input int d, output int lat, output int bcnt);
    start    = 1'b1;
    dividend = 8'(n);
    divisor  = 4'(d);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < WAIT_LIMIT) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", int'(done), 1);
  endtask

  initial begin
    int lat, bcnt, e, extra, q, r;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quot", int'(quotient), 0);
    check("rst_rem", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{225, 15, 15, 0, 0, 8, 8};
    vecs[1] = '{200, 7, 28, 4, 0, 8, 8};
    vecs[2] = '{3, 9, 0, 3, 0, 8, 8};
    vecs[3] = '{77, 0, 255, 13, ZFLAG, ZLAT, ZBUSY};
    vecs[4] = '{0, 5, 0, 0, 0, 8, 8};
    vecs[5] = '{255, 1, 255, 0, 0, 8, 8};
    vecs[6] = '{255, 15, 17, 0, 0, 8, 8};
    vecs[7] = '{16, 3, 5, 1, 0, 8, 8};
    vecs[8] = '{0, 0, 255, 0, ZFLAG, ZLAT, ZBUSY};
    vecs[9] = '{254, 13, 19, 7, 0, 8, 8};

    foreach (vecs[i]) begin
      do_div(vecs[i].n, vecs[i].d, lat, bcnt);
      check($sformatf("vec%0d_quot", i), int'(quotient), vecs[i].q);
      check($sformatf("vec%0d_rem", i), int'(remainder), vecs[i].r);
      check($sformatf("vec%0d_dbz", i), int'(div_by_zero), vecs[i].z);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), bcnt, vecs[i].bcnt);
    end

    // Second start pulsed mid-run must be dropped.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e     = 0;
    while (!done && e < WAIT_LIMIT) begin
      if (e == 3) begin
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    check("midrun_done", int'(done), 1);
    check("midrun_lat", e, 8);
    check("midrun_quot", int'(quotient), 28);
    check("midrun_rem", int'(remainder), 4);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrun_no_queued_run", extra, 0);

    // Start presented in the done cycle is accepted.
    do_div(225, 15, lat, bcnt);
    check("first_quot", int'(quotient), 15);
    check("first_rem", int'(remainder), 0);
    do_div(10, 3, lat, bcnt);
    check("donecyc_quot", int'(quotient), 3);
    check("donecyc_rem", int'(remainder), 1);
    check("donecyc_lat", lat, 8);

    // Reset in the middle of a run clears everything and returns to IDLE.
    do_div(200, 7, lat, bcnt);
    start    = 1'b1;
    dividend = 8'd225;
    divisor  = 4'd15;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quot", int'(quotient), 0);
    check("midrst_rem", int'(remainder), 0);
    check("midrst_dbz", int'(div_by_zero), 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrst_stays_idle", extra, 0);
    do_div(99, 5, lat, bcnt);
    check("postrst_quot", int'(quotient), 19);
    check("postrst_rem", int'(remainder), 4);

    // Random operands against the arithmetic reference.
    repeat (150) begin
      int n, d;
      n = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 15));
      ref_div(n, d, q, r);
      do_div(n, d, lat, bcnt);
      check($sformatf("rand_%0d_%0d_quot", n, d), int'(quotient), q);
      check($sformatf("rand_%0d_%0d_rem", n, d), int'(remainder), r);
      check($sformatf("rand_%0d_%0d_dbz", n, d), int'(div_by_zero), (d == 0) ? ZFLAG : 0);
    end

    // Full sweep of nonzero divisors: q*d + r == n and r < d.
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        do_div(n, d, lat, bcnt);
        check($sformatf("sweep_%0d_%0d_inv", n, d),
              int'((int'(quotient) * d + int'(remainder) == n) && (int'(remainder) < d)), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
